// File: rtl/if_stage.sv
// if_stage: RV32 instruction fetch stage. Owns the PC, keeps at most one
// instruction-memory request outstanding and drives the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4
);

  // state | meaning
  // FETCH | request pending at pc
  // WAIT  | granted at req_pc, awaiting rvalid
  // HOLD  | response for req_pc buffered while stall_if is high
  // KILL  | awaiting a response that must be discarded
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] KILL  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] req_pc_next;
  logic [31:0] buf_instr;
  logic [31:0] redirect_tgt;
  logic        gnt_ok;
  logic        avail;
  logic        take;
  logic [31:0] avail_instr;

  assign req_pc_next  = req_pc + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign gnt_ok       = imem_req & imem_gnt;

  // An instruction for req_pc is either arriving now or sitting in the buffer.
  assign avail       = ((state == WAIT) & imem_rvalid) | (state == HOLD);
  assign avail_instr = (state == HOLD) ? buf_instr : imem_rdata;
  assign take        = avail & ~stall_if & ~redirect_valid;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (rst) begin
      imem_addr = RESET_PC;
    end else begin
      case (state)
        FETCH: imem_req = 1'b1;
        WAIT: begin
          imem_req  = imem_rvalid & ~stall_if & ~redirect_valid;
          imem_addr = req_pc_next;
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      buf_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc <= redirect_tgt;
      case (state)
        FETCH:   state <= imem_gnt ? KILL : FETCH;
        WAIT:    state <= imem_rvalid ? FETCH : KILL;
        HOLD:    state <= FETCH;
        default: state <= imem_rvalid ? FETCH : KILL;
      endcase
    end else begin
      if (take) begin
        pc <= req_pc_next;
      end
      case (state)
        FETCH: begin
          if (gnt_ok) begin
            state  <= WAIT;
            req_pc <= pc;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (stall_if) begin
              buf_instr <= imem_rdata;
              state     <= HOLD;
            end else if (gnt_ok) begin
              req_pc <= req_pc_next;
            end else begin
              state <= FETCH;
            end
          end
        end
        HOLD: begin
          if (!stall_if) begin
            state <= FETCH;
          end
        end
        default: begin
          if (imem_rvalid) begin
            state <= FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0000_0000;
      if_id_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (!stall_if) begin
      if_id_valid <= avail;
      if_id_instr <= avail ? avail_instr : NOP_INSTR;
      if (avail) begin
        if_id_pc <= req_pc;
      end
    end
  end

  assign if_id_pc_plus4 = if_id_pc + 32'd4;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the 5-stage RISC-V pipeline. Owns the PC, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and drives the IF/ID pipeline register consumed by decode. It obeys `stall_if` from the hazard unit and takes redirects (taken branch, JAL, JALR) from the branch-resolution logic. On a redirect it squashes any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset; low 2 bits must be 0.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): bubble encoding placed in IF/ID.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_if` in 1: from the hazard unit; holds the PC and IF/ID.
- `redirect_valid` in 1: a control transfer resolved this cycle.
- `redirect_pc` in 32: target address; bits [1:0] ignored and treated as 0.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid. Arrives at least 1 cycle after `gnt`, exactly once per grant.
- `imem_rdata` in 32: instruction word.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_instr` out 32: instruction, or `NOP_INSTR` when not valid.
- `if_id_pc_plus4` out 32: `if_id_pc + 4`, modulo 2^32.

## Operation
- There are 4 states: FETCH (request pending), WAIT (granted, awaiting rvalid), HOLD (response buffered during stall), KILL (awaiting a response that must be discarded).
- `imem_req` is asserted in these cases:
  - FETCH;
  - WAIT when `imem_rvalid & ~stall_if & ~redirect_valid` (back-to-back issue).
- It is never asserted during `rst`, HOLD or KILL.
- `imem_addr` is `pc` in FETCH and `pc+4` in WAIT.
- `imem_req` is held until granted. The address may change only on a redirect.
- **FETCH**
  - On `gnt`: go to WAIT, latch `req_pc` = issued address.
- **WAIT**, on `rvalid`:
  - If `~stall_if`: load IF/ID with {1, req_pc, rdata} and set `pc <= req_pc+4`. If the back-to-back request is granted, stay in WAIT with `req_pc` = new address; otherwise go to FETCH.
  - If `stall_if`: capture rdata into a 1-entry buffer and go to HOLD.
- **HOLD**
  - While `stall_if`, hold.
  - On release: load IF/ID from the buffer, set `pc <= req_pc+4`, go to FETCH.
- **KILL**
  - On `rvalid`: discard the data, go to FETCH.
- **IF/ID register update**, in priority order:
  1. `rst`
  2. `redirect_valid`: load a bubble {0, NOP_INSTR}.
  3. `stall_if`: hold.
  4. An instruction is available: load it.
  5. Otherwise load a bubble.
- **Redirect** (highest priority after `rst`) sets `pc <= {redirect_pc[31:2],2'b00}`. The next state depends on the current one:
  - FETCH without gnt: stay in FETCH with the new address.
  - FETCH with gnt: go to KILL.
  - WAIT without rvalid: go to KILL.
  - WAIT with rvalid: discard the data, go to FETCH.
  - HOLD: drop the buffer, go to FETCH.
  - KILL without rvalid: stay in KILL.
  - KILL with rvalid: go to FETCH.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- **Reset values:**
  - `pc = RESET_PC`, state FETCH, buffer empty.
  - `if_id_valid = 0`, `if_id_instr = NOP_INSTR`, `if_id_pc = 0`, `if_id_pc_plus4 = 4`.
  - `imem_req = 0`, `imem_addr = RESET_PC`.
- Reset asserted mid-transaction abandons any outstanding response. After reset is released, the block discards `imem_rvalid` until the first new grant.

## Timing
- Request-to-IF/ID latency with a zero-wait memory (gnt in cycle N, rvalid in N+1): IF/ID valid after the edge ending N+1.
- Steady-state throughput is 1 instruction/cycle with a zero-wait memory.
- `stall_if` is combinational from the hazard unit. The block samples it at the edge and never uses it to gate `imem_gnt` acceptance.
- Redirect penalty: the first target instruction reaches IF/ID no earlier than 2 edges after `redirect_valid`. If a fetch was in flight, add that fetch's remaining latency.
- There is at most one outstanding grant at any time.

## Test plan
- **Reset and stream.** Drive `rst` for 2 cycles, then a zero-wait memory returning `addr^32'hA5A5_0000`. Required: `imem_req=0` during reset, first address 0, and IF/ID shows pc 0,4,8,12 on consecutive cycles with `if_id_valid=1`.
- **Load-use stall.** Assert `stall_if` for 2 cycles while the response for pc 8 arrives. Required: IF/ID holds pc 4 for both cycles, the pc 8 data is buffered (HOLD), then appears with pc 8, and no duplicate request for 8 is issued.
- **Redirect while waiting.** Use a memory with 3-cycle latency. Assert `redirect_valid` with target 32'h100 while in WAIT for pc 0x10. Required: the 0x10 data is discarded, the next request address is 32'h100, and IF/ID is a bubble until the 0x100 instruction arrives.
- **Redirect and stall together.** Assert `stall_if=1` and `redirect_valid=1` (target 0x43, i.e. unaligned) in the same cycle. Required: IF/ID becomes {0, NOP_INSTR} and the next `imem_addr` is 0x40.
- **PC wrap.** Redirect to 32'hFFFF_FFFC and stream. Required: IF/ID pc 0xFFFF_FFFC with `pc_plus4` 0, then pc 0.
- **Reset mid-fetch.** Assert `rst` while in WAIT, and deliver a late `rvalid` 1 cycle after release. Required: the late data is ignored, and the first IF/ID instruction has pc `RESET_PC`.
